imm_encoder: RTL and testbench
==============================

IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, SHALL be the reset and flush value of the emit address counter.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 flush  input  1  synchronous clear of the output stage and address counter.
REQ-005 in_valid  input  1  request carries a valid encode command.
REQ-006 in_ready  output  1  encoder accepts a command this cycle.
REQ-007 in_fmt  input  2  format: 0=I-ALU (0010011), 1=I-LOAD (0000011), 2=S (0100011), 3=B (1100011).
REQ-008 in_funct3 / in_rd / in_rs1 / in_rs2  input  3/5/5/5  instruction fields.
REQ-009 in_imm  input  32  signed byte-offset immediate.
REQ-010 out_valid  output  1  out_instr/out_addr are valid.
REQ-011 out_ready  input  1  consumer accepts the output this cycle.
REQ-012 out_instr  output  32  encoded instruction word.
REQ-013 out_addr  output  32  address assigned to out_instr.
REQ-014 err_pulse  output  1  one-cycle pulse when an accepted command is rejected.
REQ-015 err_cnt  output  8  saturating count of rejected commands.

Function
REQ-016 Handshake: a command transfers when in_valid && in_ready; an output transfers when out_valid && out_ready.
REQ-017 in_ready SHALL equal (!out_valid || out_ready) && !flush.
REQ-018 Output stage SHALL be a single-register FSM with states EMPTY and FULL; EMPTY->FULL on accepted valid command; FULL->EMPTY on output transfer with no new accept; FULL->FULL on simultaneous transfer and accept (new word loaded, no bubble).
REQ-019 Latency: an accepted command SHALL appear on out_instr exactly one cycle later.
REQ-020 While FULL and !out_ready, out_instr, out_addr and out_valid SHALL hold stable.
REQ-021 I formats SHALL encode {imm[11:0], rs1, funct3, rd, opcode}; in_rs2 ignored.
REQ-022 S SHALL encode {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}; in_rd ignored.
REQ-023 B SHALL encode {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}; in_rd ignored.
REQ-024 Range rule I/S: in_imm[31:11] SHALL be all-equal; B: in_imm[31:12] all-equal and in_imm[0]==0.
REQ-025 A command violating REQ-024 SHALL be accepted but not emitted: FSM state unchanged except for any simultaneous output transfer, address unchanged, err_pulse=1 next cycle, err_cnt+1 saturating at 255.
REQ-026 out_addr SHALL equal the counter at load time; the counter SHALL advance by 4 per emitted (not rejected) word, wrapping modulo 2^32.
REQ-027 flush SHALL, next cycle, force EMPTY, out_valid=0, counter=BASE_ADDR; err_cnt retained; commands presented during flush are not accepted.

Reset
REQ-028 On reset: state EMPTY, out_valid=0, out_instr=0, out_addr=BASE_ADDR, counter=BASE_ADDR, err_pulse=0, err_cnt=0.
REQ-029 Reset SHALL take priority over flush and any handshake; a word held in FULL at reset SHALL be discarded.

Structure
REQ-030 Shared package SHALL hold the fmt encoding constants and the four 7-bit opcode constants, shared with the immediate decoder.
REQ-031 Field packing and range checking SHALL be a combinational sub-module imm_pack; imm_encoder owns the FSM, counter and error logic.

Verification
REQ-032 fmt=0, rd=1, rs1=0, f3=0, imm=5 -> out_instr=0x00500093, out_addr=BASE_ADDR, one cycle after accept.
REQ-033 fmt=2, rs1=1, rs2=2, f3=2, imm=8 then fmt=3, rs1=1, rs2=2, f3=0, imm=-8, back-to-back with out_ready=1 -> 0x0020A423 @BASE, 0xFE208CE3 @BASE+4, no bubble.
REQ-034 fmt=1, rd=3, rs1=2, f3=2, imm=-4 with out_ready=0 for 3 cycles -> 0xFFC12183 held stable, in_ready=0, then a single transfer.
REQ-035 fmt=3, imm=7 (odd) and fmt=0, imm=2048 -> nothing emitted, two err_pulses, err_cnt=2, counter unchanged; 300 violations -> err_cnt=255.
REQ-036 BASE_ADDR=32'hFFFF_FFFC, two valid commands -> out_addr 0xFFFFFFFC then 0x00000000; flush or reset while FULL -> out_valid=0 next cycle, next word at BASE_ADDR.

Source files
------------

// File: rtl/imm_encoder_pkg.sv
// Shared encodings for the immediate encoder and decoder: format codes, base
// opcodes, output-stage states and the immediate range check.
package imm_encoder_pkg;

    typedef enum logic [1:0] {
        FMT_I_ALU  = 2'd0,
        FMT_I_LOAD = 2'd1,
        FMT_S      = 2'd2,
        FMT_B      = 2'd3
    } fmt_e;

    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_I_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_S      = 7'b0100011;
    localparam logic [6:0] OPC_B      = 7'b1100011;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ostate_e;

    // I/S take a 12-bit signed field; B takes a 13-bit signed, even offset.
    function automatic logic imm_in_range(input logic [31:0] imm, input logic is_b);
        logic ok;
        if (is_b) begin
            ok = ((&imm[31:12]) || (~|imm[31:12])) && (imm[0] == 1'b0);
        end else begin
            ok = (&imm[31:11]) || (~|imm[31:11]);
        end
        return ok;
    endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// Combinational field packer: builds the instruction word for the requested
// format and flags immediates that do not fit it.
module imm_pack
    import imm_encoder_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        ok
);

    fmt_e fmt_s;
    assign fmt_s = fmt_e'(fmt);

    // Field packing and range check per format.
    always_comb begin
        instr = 32'h0000_0000;
        ok    = 1'b0;
        case (fmt_s)
            FMT_I_ALU: begin
                instr = {imm[11:0], rs1, funct3, rd, OPC_I_ALU};
                ok    = imm_in_range(imm, 1'b0);
            end
            FMT_I_LOAD: begin
                instr = {imm[11:0], rs1, funct3, rd, OPC_I_LOAD};
                ok    = imm_in_range(imm, 1'b0);
            end
            FMT_S: begin
                instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_S};
                ok    = imm_in_range(imm, 1'b0);
            end
            FMT_B: begin
                instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_B};
                ok    = imm_in_range(imm, 1'b1);
            end
            default: begin
                instr = 32'h0000_0000;
                ok    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: one-deep output register with valid/ready handshakes,
// an emit address counter and a saturating reject counter.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_fmt,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err_pulse,
    output logic [7:0]  err_cnt
);

    ostate_e     state_r;
    ostate_e     state_nxt_s;
    logic [31:0] addr_r;
    logic [31:0] instr_s;
    logic        ok_s;
    logic        accept_s;
    logic        emit_s;
    logic        reject_s;
    logic        xfer_s;

    imm_pack u_pack (
        .fmt    (in_fmt),
        .funct3 (in_funct3),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .imm    (in_imm),
        .instr  (instr_s),
        .ok     (ok_s)
    );

    assign out_valid = (state_r == ST_FULL);
    assign in_ready  = (!out_valid || out_ready) && !flush;
    assign accept_s  = in_valid && in_ready;
    assign emit_s    = accept_s && ok_s;
    assign reject_s  = accept_s && !ok_s;
    assign xfer_s    = out_valid && out_ready;

    // Output-stage next state; a rejected command never loads the register.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (emit_s) begin
                    state_nxt_s = ST_FULL;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (emit_s) begin
                    state_nxt_s = ST_FULL;
                end else if (xfer_s) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // State, output word, address counter and error bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_EMPTY;
            out_instr <= 32'h0000_0000;
            out_addr  <= BASE_ADDR;
            addr_r    <= BASE_ADDR;
            err_pulse <= 1'b0;
            err_cnt   <= 8'd0;
        end else if (flush) begin
            state_r   <= ST_EMPTY;
            addr_r    <= BASE_ADDR;
            err_pulse <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            err_pulse <= reject_s;
            if (emit_s) begin
                out_instr <= instr_s;
                out_addr  <= addr_r;
                addr_r    <= addr_r + 32'd4;
            end
            if (reject_s && (err_cnt != 8'd255)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed literal checks followed by randomized
// traffic compared every cycle against a behavioural model.
module tb_imm_encoder;

    localparam logic [31:0] TB_BASE = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready, err_pulse;
    logic [1:0]  in_fmt;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm, out_instr, out_addr;
    logic [7:0]  err_cnt;

    int tests = 0;
    int fails = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    imm_encoder #(.BASE_ADDR(TB_BASE)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
        .in_funct3(in_funct3), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    function automatic logic [31:0] ref_enc(input logic [1:0] f, input logic [2:0] f3,
                                            input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2, input logic [31:0] imm);
        logic [31:0] w;
        case (f)
            2'd0:    w = {imm[11:0], rs1, f3, rd, 7'h13};
            2'd1:    w = {imm[11:0], rs1, f3, rd, 7'h03};
            2'd2:    w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
            default: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
        endcase
        return w;
    endfunction

    function automatic logic ref_ok(input logic [1:0] f, input logic [31:0] imm);
        int s;
        s = $signed(imm);
        if (f == 2'd3) return (s >= -4096) && (s <= 4095) && ((s % 2) == 0);
        return (s >= -2048) && (s <= 2047);
    endfunction

    // Behavioural model of the visible outputs.
    logic        m_valid, m_ep;
    logic [31:0] m_instr, m_addr, m_ctr;
    logic [7:0]  m_ec;
    logic        m_ready, m_acc, m_ok;
    assign m_ready = (!m_valid || out_ready) && !flush;
    assign m_acc   = in_valid && m_ready;
    assign m_ok    = ref_ok(in_fmt, in_imm);

    always @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0; m_instr <= 32'd0; m_addr <= TB_BASE;
            m_ctr <= TB_BASE; m_ep <= 1'b0; m_ec <= 8'd0;
        end else if (flush) begin
            m_valid <= 1'b0; m_ctr <= TB_BASE; m_ep <= 1'b0;
        end else begin
            if (m_acc && m_ok) begin
                m_valid <= 1'b1;
                m_instr <= ref_enc(in_fmt, in_funct3, in_rd, in_rs1, in_rs2, in_imm);
                m_addr  <= m_ctr;
                m_ctr   <= m_ctr + 32'd4;
            end else if (m_valid && out_ready) begin
                m_valid <= 1'b0;
            end
            m_ep <= m_acc && !m_ok;
            if (m_acc && !m_ok) m_ec <= (m_ec == 8'd255) ? 8'd255 : m_ec + 8'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
            check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            check("err_pulse", {31'd0, err_pulse}, {31'd0, m_ep});
            check("err_cnt", {24'd0, err_cnt}, {24'd0, m_ec});
            if (m_valid) begin
                check("out_instr", out_instr, m_instr);
                check("out_addr", out_addr, m_addr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] f, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        in_valid = 1'b1; in_fmt = f; in_funct3 = f3;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    endtask

    int edges [8] = '{2047, -2048, 2048, -2049, 4094, -4096, 4096, 4095};

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_fmt = 2'd0; in_funct3 = 3'd0; in_rd = 5'd0; in_rs1 = 5'd0;
        in_rs2 = 5'd0; in_imm = 32'd0;
        tick(); tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_addr", out_addr, TB_BASE);
        check("rst_errcnt", {24'd0, err_cnt}, 32'd0);
        check("model_i", ref_enc(2'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5), 32'h0050_0093);
        check("model_s", ref_enc(2'd2, 3'd2, 5'd0, 5'd1, 5'd2, 32'd8), 32'h0020_A423);
        check("model_b", ref_enc(2'd3, 3'd0, 5'd0, 5'd1, 5'd2, -32'sd8), 32'hFE20_8CE3);
        check("model_odd", {31'd0, ref_ok(2'd3, 32'd7)}, 32'd0);
        check("model_2048", {31'd0, ref_ok(2'd0, 32'd2048)}, 32'd0);
        check("model_m2048", {31'd0, ref_ok(2'd0, -32'sd2048)}, 32'd1);
        chk_en = 1'b1;
        reset = 1'b0;

        // Basic I-ALU word, one cycle after accept.
        cmd(2'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        tick();
        check("addi_instr", out_instr, 32'h0050_0093);
        check("addi_addr", out_addr, TB_BASE);
        in_valid = 1'b0;
        tick();
        check("addi_drain", {31'd0, out_valid}, 32'd0);

        // Flush with a command presented: nothing accepted, counter rewound.
        flush = 1'b1;
        cmd(2'd0, 3'd0, 5'd7, 5'd0, 5'd0, 32'd1);
        tick();
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0; in_valid = 1'b0;

        // Back-to-back S then B, no bubble, address wraps past 2^32.
        cmd(2'd2, 3'd2, 5'd0, 5'd1, 5'd2, 32'd8);
        tick();
        check("s_instr", out_instr, 32'h0020_A423);
        check("s_addr", out_addr, TB_BASE);
        cmd(2'd3, 3'd0, 5'd0, 5'd1, 5'd2, -32'sd8);
        tick();
        check("b_valid", {31'd0, out_valid}, 32'd1);
        check("b_instr", out_instr, 32'hFE20_8CE3);
        check("b_addr", out_addr, 32'h0000_0000);
        in_valid = 1'b0;
        tick();

        // Backpressure: word holds for 3 cycles, then exactly one transfer.
        out_ready = 1'b0;
        cmd(2'd1, 3'd2, 5'd3, 5'd2, 5'd0, -32'sd4);
        tick();
        cmd(2'd0, 3'd0, 5'd5, 5'd5, 5'd0, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("hold_instr", out_instr, 32'hFFC1_2183);
            check("hold_addr", out_addr, 32'h0000_0004);
            check("hold_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1; in_valid = 1'b0;
        tick();
        check("hold_release", {31'd0, out_valid}, 32'd0);

        // Range violations: rejected, counted, counter untouched.
        cmd(2'd3, 3'd0, 5'd0, 5'd1, 5'd2, 32'd7);
        tick();
        check("odd_pulse", {31'd0, err_pulse}, 32'd1);
        check("odd_valid", {31'd0, out_valid}, 32'd0);
        cmd(2'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        tick();
        check("big_pulse", {31'd0, err_pulse}, 32'd1);
        check("big_cnt", {24'd0, err_cnt}, 32'd2);
        in_valid = 1'b0;
        tick();
        check("pulse_clear", {31'd0, err_pulse}, 32'd0);
        cmd(2'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        tick();
        check("after_err_addr", out_addr, 32'h0000_0008);
        for (int i = 0; i < 300; i++) begin
            cmd(2'd3, 3'd0, 5'd0, 5'd0, 5'd0, 32'd1);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("err_sat", {24'd0, err_cnt}, 32'd255);

        // Flush while FULL.
        out_ready = 1'b0;
        cmd(2'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd3);
        tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        check("flush_full", {31'd0, out_valid}, 32'd0);
        flush = 1'b0; out_ready = 1'b1;
        cmd(2'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd3);
        tick();
        check("flush_addr", out_addr, TB_BASE);
        check("flush_errcnt", {24'd0, err_cnt}, 32'd255);

        // Reset while FULL.
        out_ready = 1'b0;
        cmd(2'd0, 3'd0, 5'd2, 5'd0, 5'd0, 32'd9);
        tick();
        in_valid = 1'b0; reset = 1'b1;
        tick();
        check("reset_full", {31'd0, out_valid}, 32'd0);
        check("reset_errcnt", {24'd0, err_cnt}, 32'd0);
        reset = 1'b0; out_ready = 1'b1;
        cmd(2'd0, 3'd0, 5'd2, 5'd0, 5'd0, 32'd9);
        tick();
        check("reset_addr", out_addr, TB_BASE);
        in_valid = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            reset     = ($urandom_range(0, 299) == 0);
            in_fmt    = 2'($urandom_range(0, 3));
            in_funct3 = 3'($urandom);
            in_rd     = 5'($urandom);
            in_rs1    = 5'($urandom);
            in_rs2    = 5'($urandom);
            case ($urandom_range(0, 3))
                0:       in_imm = $urandom;
                1:       in_imm = 32'($signed($urandom_range(0, 8400)) - 4200);
                2:       in_imm = edges[$urandom_range(0, 7)];
                default: in_imm = 32'($signed($urandom_range(0, 2047)) * 2 - 2048);
            endcase
            tick();
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
